// File: rtl/stream_frame_receptor.sv
// AXI-Stream frame sink: per-frame byte checksum/length, inter-frame gap throttling, byte-wide CSRs.
// Define FRAME_RECEPTOR_MAXLEN_EN to add the MAX_LEN truncation register at CSR 11..12.
module stream_frame_receptor #(
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 16,
  parameter int CKSUM_W = 32
)(
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          writedata,
  input  logic                write,
  input  logic                chipselect,
  input  logic [7:0]          address,
  input  logic                read,
  output logic [7:0]          readdata,
  input  logic [DATA_W-1:0]   ingress_port_tdata,
  input  logic [DATA_W/8-1:0] ingress_port_tkeep,
  input  logic                ingress_port_tvalid,
  output logic                ingress_port_tready,
  input  logic                ingress_port_tlast
);
  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WAIT} state_t;
  state_t state;

  logic [7:0]         ifg, gap, rd_byte;
  logic               ctrl_en, len_ovf, too_long;
  logic [CKSUM_W-1:0] cksum_run, last_cksum, beat_sum, cksum_nxt;
  logic [CNT_W-1:0]   len_run, last_len, frame_cnt, beat_len, len_nxt;
  logic [CNT_W:0]     len_sum;
  logic               accept, csr_wr, csr_rd, clear, beat_drop, ovf_nxt;
  logic [31:0]        cks_ext;
  logic [15:0]        len_ext, cnt_ext;

  // tready depends only on registered state, never on tvalid
  assign ingress_port_tready = ctrl_en && (state != S_WAIT);
  assign accept = ingress_port_tvalid && ingress_port_tready;
  assign csr_wr = chipselect && write;
  assign csr_rd = chipselect && read;
  assign clear  = csr_wr && (address == 8'd1) && writedata[1];

  always_comb begin
    beat_sum = '0;
    beat_len = '0;
    for (int i = 0; i < NB; i++) begin
      if (ingress_port_tkeep[i]) begin
        beat_sum = beat_sum + CKSUM_W'(ingress_port_tdata[8*i +: 8]);
        beat_len = beat_len + CNT_W'(1);
      end
    end
  end

  assign len_sum = {1'b0, len_run} + {1'b0, beat_len};

`ifdef FRAME_RECEPTOR_MAXLEN_EN
  logic [15:0] max_len;
  logic        trunc;
  // once a frame overruns MAX_LEN, every later beat of it is accepted but ignored
  assign beat_drop = trunc || ((max_len != 16'd0) && (32'(len_sum) > 32'(max_len)));
`else
  assign beat_drop = 1'b0;
`endif

  assign cksum_nxt = beat_drop ? cksum_run : cksum_run + beat_sum;
  assign len_nxt   = beat_drop ? len_run : (len_sum[CNT_W] ? '1 : len_sum[CNT_W-1:0]);
  assign ovf_nxt   = !beat_drop && len_sum[CNT_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ifg        <= '0;
      gap        <= '0;
      ctrl_en    <= 1'b0;
      cksum_run  <= '0;
      last_cksum <= '0;
      len_run    <= '0;
      last_len   <= '0;
      frame_cnt  <= '0;
      len_ovf    <= 1'b0;
      too_long   <= 1'b0;
`ifdef FRAME_RECEPTOR_MAXLEN_EN
      max_len    <= '0;
      trunc      <= 1'b0;
`endif
    end else begin
      if (csr_wr) begin
        case (address)
          8'd0: ifg     <= writedata;
          8'd1: ctrl_en <= writedata[0];
`ifdef FRAME_RECEPTOR_MAXLEN_EN
          8'd11: max_len[7:0]  <= writedata;
          8'd12: max_len[15:8] <= writedata;
`endif
          default: ;
        endcase
      end

      case (state)
        S_IDLE, S_RECV: begin
          if (accept) begin
            if (ingress_port_tlast) begin
              state <= (ifg != 8'd0) ? S_WAIT : S_IDLE;
              gap   <= ifg;
            end else begin
              state <= S_RECV;
            end
          end
        end
        S_WAIT: begin
          if (gap <= 8'd1) state <= S_IDLE;
          else             gap   <= gap - 8'd1;
        end
        default: state <= S_IDLE;
      endcase

      if (accept) begin
        if (ingress_port_tlast) begin
          last_cksum <= cksum_nxt;
          last_len   <= len_nxt;
          cksum_run  <= '0;
          len_run    <= '0;
          frame_cnt  <= frame_cnt + CNT_W'(1);
`ifdef FRAME_RECEPTOR_MAXLEN_EN
          trunc      <= 1'b0;
`endif
        end else begin
          cksum_run  <= cksum_nxt;
          len_run    <= len_nxt;
`ifdef FRAME_RECEPTOR_MAXLEN_EN
          trunc      <= beat_drop;
`endif
        end
        if (ovf_nxt)   len_ovf  <= 1'b1;
        if (beat_drop) too_long <= 1'b1;
      end

      // clear has priority over a same-cycle frame count increment
      if (clear) begin
        frame_cnt <= '0;
        len_ovf   <= 1'b0;
        too_long  <= 1'b0;
      end
    end
  end

  assign cks_ext = 32'(last_cksum);
  assign len_ext = 16'(last_len);
  assign cnt_ext = 16'(frame_cnt);

  always_comb begin
    rd_byte = '0;
    case (address)
      8'd0:  rd_byte = ifg;
      8'd1:  rd_byte = {7'b0, ctrl_en};
      8'd2:  rd_byte = cks_ext[7:0];
      8'd3:  rd_byte = cks_ext[15:8];
      8'd4:  rd_byte = cks_ext[23:16];
      8'd5:  rd_byte = cks_ext[31:24];
      8'd6:  rd_byte = len_ext[7:0];
      8'd7:  rd_byte = len_ext[15:8];
      8'd8:  rd_byte = cnt_ext[7:0];
      8'd9:  rd_byte = cnt_ext[15:8];
      8'd10: rd_byte = {5'b0, too_long, len_ovf, state == S_RECV};
`ifdef FRAME_RECEPTOR_MAXLEN_EN
      8'd11: rd_byte = max_len[7:0];
      8'd12: rd_byte = max_len[15:8];
`endif
      default: rd_byte = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)       readdata <= '0;
    else if (csr_rd) readdata <= rd_byte;
    else             readdata <= '0;
  end
endmodule

// File: tb/tb_stream_frame_receptor.sv
// Directed + randomized bench for stream_frame_receptor (DATA_W=16); reference model sums kept bytes per frame.
// The MAX_LEN section only runs when FRAME_RECEPTOR_MAXLEN_EN is defined.
module tb_stream_frame_receptor;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  writedata, address, readdata;
  logic        write, chipselect, read;
  logic [15:0] tdata;
  logic [1:0]  tkeep;
  logic        tvalid, tready, tlast;

  int passed = 0;
  int total  = 0;

  logic [15:0] fd[8];
  logic [1:0]  fk[8];
  logic [31:0] m_cksum, m_len, m_cnt;

  stream_frame_receptor #(.DATA_W(16), .CNT_W(16), .CKSUM_W(32)) dut (
    .clk(clk), .reset(reset), .writedata(writedata), .write(write),
    .chipselect(chipselect), .address(address), .read(read), .readdata(readdata),
    .ingress_port_tdata(tdata), .ingress_port_tkeep(tkeep),
    .ingress_port_tvalid(tvalid), .ingress_port_tready(tready),
    .ingress_port_tlast(tlast)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic csr_write(input logic [7:0] a, input logic [7:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic csr_read(input logic [7:0] a, output logic [7:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic read_multi(input logic [7:0] a, input int n, output logic [31:0] v);
    logic [7:0] b;
    v = '0;
    for (int i = 0; i < n; i++) begin
      csr_read(a + 8'(i), b);
      v[8*i +: 8] = b;
    end
  endtask

  // Drives one beat and returns once it is accepted; waits = cycles spent with tready low.
  task automatic send_beat(input logic [15:0] d, input logic [1:0] k, input logic l, output int waits);
    logic rdy;
    waits = 0;
    rdy = 1'b0;
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = l;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); rdy = tready;
      @(posedge clk); #1;
      if (rdy) return;
      waits++;
    end
    check("beat_timeout", 32'(rdy), 32'd1);
  endtask

  // Reference: checksum/length of a frame are the sum/count of its kept bytes.
  task automatic model_frame(input int n);
    m_cksum = 0; m_len = 0;
    for (int b = 0; b < n; b++)
      for (int j = 0; j < 2; j++)
        if (fk[b][j]) begin
          m_cksum = m_cksum + 32'((fd[b] >> (8*j)) & 16'hFF);
          m_len++;
        end
  endtask

  task automatic send_frame(input int n, input bit hold, output int first_waits, output int all_waits);
    int w;
    all_waits = 0; first_waits = 0;
    for (int b = 0; b < n; b++) begin
      send_beat(fd[b], fk[b], b == n - 1, w);
      if (b == 0) first_waits = w;
      all_waits += w;
    end
    if (!hold) tvalid = 1'b0;
    model_frame(n);
    m_cnt = (m_cnt + 1) & 32'hFFFF;
  endtask

  task automatic check_last(input string tag);
    logic [31:0] v;
    read_multi(8'd2, 4, v); check({tag, "_cksum"}, v, m_cksum);
    read_multi(8'd6, 2, v); check({tag, "_len"}, v, m_len);
    read_multi(8'd8, 2, v); check({tag, "_cnt"}, v, m_cnt);
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] v;
    int w0, wa, n;

    reset = 1'b1; write = 0; read = 0; chipselect = 0; address = 0; writedata = 0;
    tvalid = 0; tdata = 0; tkeep = 0; tlast = 0;
    m_cnt = 0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_readdata", 32'(readdata), 32'd0);
    check("rst_tready", 32'(tready), 32'd0);
    for (int a = 0; a <= 12; a++) begin
      csr_read(8'(a), b);
      check($sformatf("rst_csr%0d", a), 32'(b), 32'd0);
    end
    tick();
    check("readdata_idle", 32'(readdata), 32'd0);
    check("tready_before_en", 32'(tready), 32'd0);

    csr_write(8'd0, 8'd0);
    csr_write(8'd1, 8'h01);
    check("tready_after_en", 32'(tready), 32'd1);
    csr_read(8'd1, b);
    check("ctrl_readback", 32'(b), 32'd1);

    // directed full-keep frame
    fd[0] = 16'h0201; fk[0] = 2'b11;
    fd[1] = 16'h0403; fk[1] = 2'b11;
    fd[2] = 16'h0605; fk[2] = 2'b11;
    send_frame(3, 0, w0, wa);
    check("d1_no_stall", 32'(wa), 32'd0);
    check("d1_model_cksum", m_cksum, 32'h15);
    check_last("d1");

    // partial keep on last beat
    fd[2] = 16'hFF07; fk[2] = 2'b01;
    send_frame(3, 0, w0, wa);
    check("d2_model_len", m_len, 32'd5);
    check_last("d2");

    // inter-frame gap with tvalid held high
    csr_write(8'd1, 8'h03); m_cnt = 0;
    csr_write(8'd0, 8'd4);
    fd[0] = 16'h1122; fk[0] = 2'b11;
    fd[1] = 16'h3344; fk[1] = 2'b10;
    send_frame(2, 1, w0, wa);
    send_frame(2, 1, w0, wa);
    check("ifg_gap_a", 32'(w0), 32'd4);
    send_beat(16'h5566, 2'b11, 1'b0, w0);
    tvalid = 1'b0;
    check("ifg_gap_b", 32'(w0), 32'd4);
    read_multi(8'd8, 2, v); check("ifg_cnt", v, 32'd2);
    csr_read(8'd10, b); check("ifg_in_frame", 32'(b), 32'h01);
    send_beat(16'h7788, 2'b11, 1'b1, w0);
    tvalid = 1'b0;
    m_cnt = 3;
    read_multi(8'd8, 2, v); check("ifg_cnt3", v, m_cnt);

    // disable mid-frame, resume later
    csr_write(8'd0, 8'd0);
    repeat (6) tick();
    fd[0] = 16'hA1B2; fk[0] = 2'b11;
    fd[1] = 16'hC3D4; fk[1] = 2'b01;
    fd[2] = 16'hE5F6; fk[2] = 2'b11;
    send_beat(fd[0], fk[0], 1'b0, w0);
    tvalid = 1'b0;
    csr_write(8'd1, 8'h00);
    tvalid = 1'b1; tdata = fd[1]; tkeep = fk[1]; tlast = 1'b0;
    repeat (10) tick();
    check("dis_tready_low", 32'(tready), 32'd0);
    csr_read(8'd10, b); check("dis_in_frame", 32'(b), 32'h01);
    tvalid = 1'b0;
    csr_write(8'd1, 8'h01);
    send_beat(fd[1], fk[1], 1'b0, w0);
    send_beat(fd[2], fk[2], 1'b1, w0);
    tvalid = 1'b0;
    model_frame(3); m_cnt = m_cnt + 1;
    check_last("dis");

    // randomized frames, random IFG and keep (including tkeep=0)
    for (int f = 0; f < 20; f++) begin
      csr_write(8'd0, 8'($urandom_range(0, 3)));
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        fd[k] = 16'($urandom);
        fk[k] = 2'($urandom_range(0, 3));
      end
      send_frame(n, 0, w0, wa);
      check_last($sformatf("rnd%0d", f));
    end

    // clear coinciding with a tlast accept: count clears, LAST_* still update
    csr_write(8'd0, 8'd0);
    repeat (4) tick();
    check("clr_tready", 32'(tready), 32'd1);
    tvalid = 1'b1; tdata = 16'h3344; tkeep = 2'b11; tlast = 1'b1;
    chipselect = 1'b1; write = 1'b1; address = 8'd1; writedata = 8'h03;
    tick();
    tvalid = 1'b0; chipselect = 1'b0; write = 1'b0;
    m_cksum = 32'h77; m_len = 2; m_cnt = 0;
    check_last("clr_tlast");

`ifdef FRAME_RECEPTOR_MAXLEN_EN
    csr_write(8'd11, 8'd4);
    csr_write(8'd12, 8'd0);
    fd[0] = 16'h0201; fk[0] = 2'b11;
    fd[1] = 16'h0403; fk[1] = 2'b11;
    fd[2] = 16'h0605; fk[2] = 2'b11;
    send_frame(3, 0, w0, wa);
    m_cksum = 32'd10; m_len = 4;
    check_last("maxlen");
    csr_read(8'd10, b); check("maxlen_too_long", 32'(b[2]), 32'd1);
    csr_write(8'd1, 8'h03); m_cnt = 0;
    csr_read(8'd10, b); check("maxlen_clr", 32'(b[2]), 32'd0);
    csr_write(8'd11, 8'd0);
`else
    csr_read(8'd10, b); check("status_no_too_long", 32'(b[2]), 32'd0);
`endif

    // reset mid-frame discards the partial frame
    send_beat(16'hAAAA, 2'b11, 1'b0, w0);
    tvalid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst2_tready", 32'(tready), 32'd0);
    csr_write(8'd1, 8'h01);
    fd[0] = 16'h0102; fk[0] = 2'b11;
    m_cnt = 0;
    send_frame(1, 0, w0, wa);
    check_last("rst2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stream_frame_receptor.md
Name: stream_frame_receptor

Overview:
Parametrised ingress frame sink for the packet filter. It accepts AXI-Stream frames of configurable width with byte qualifiers, and computes a per-frame byte checksum and length. It enforces a programmable inter-frame gap by throttling tready, and exposes results and statistics through a byte-wide Avalon-MM CSR slave.

Parameters:
DATA_W, 16, stream data width in bits; multiple of 8, range 8..64
CNT_W, 16, width of frame-length and frame-count registers
CKSUM_W, 32, checksum accumulator width; multiple of 8, at most 32

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
writedata  in  8  CSR write data
write  in  1  CSR write strobe
chipselect  in  1  CSR select
address  in  8  CSR byte address
read  in  1  CSR read strobe
readdata  out  8  CSR read data, registered
ingress_port_tdata  in  DATA_W  stream data; byte 0 at bits [7:0]
ingress_port_tkeep  in  DATA_W/8  byte-valid qualifiers
ingress_port_tvalid  in  1  beat valid
ingress_port_tready  out  1  beat ready
ingress_port_tlast  in  1  last beat of frame

Behaviour:
- Interface: reset is named reset, synchronous, active-high; the clock is clk.
- Reset values: readdata=0 and tready=0. All CSRs, accumulators and counters are 0. The FSM is in IDLE.
- CSR map:
  - 0: IFG, RW
  - 1: CTRL, RW; bit0 enable; bit1 clear, write-1 self-clearing, reads 0
  - 2..5: LAST_CKSUM, R, little-endian
  - 6..7: LAST_LEN, R
  - 8..9: FRAME_CNT, R
  - 10: STATUS, R; bit0 in_frame, bit1 len_ovf sticky, bit2 too_long sticky
  - All other addresses read 0; writes to them are ignored.
  - Fields narrower than the address span read 0 in the unused bytes.
- CSR reads have 1-cycle latency. readdata is 0 in any cycle following no read.
- Beat accept: a beat is accepted when tvalid and tready are both high. tready = CTRL.enable and state != WAIT, registered off state and enable; no combinational path from tvalid.
- FSM:
  - IDLE: an accepted beat without tlast goes to RECV. An accepted beat with tlast goes to WAIT if IFG != 0, else stays in IDLE.
  - RECV: an accepted beat with tlast goes to WAIT if IFG != 0, else to IDLE.
  - WAIT: loads gap counter = IFG on entry and decrements each cycle. Leaves to IDLE when the counter reaches 1. tready is therefore low for exactly IFG cycles after the tlast accept cycle.
- Per accepted beat:
  - cksum_run += sum of tdata bytes whose tkeep bit is set, modulo 2^CKSUM_W.
  - len_run += popcount(tkeep). len_run saturates at all-ones and then sets len_ovf.
  - A beat with tkeep=0 adds nothing but still counts as a beat; its tlast is honoured.
- On a tlast accept:
  - LAST_CKSUM and LAST_LEN take the values including that beat.
  - FRAME_CNT increments, wrapping modulo 2^CNT_W.
  - cksum_run and len_run clear.
- in_frame = (state == RECV).
- Disable mid-frame: tready drops and the running state is held. Re-enabling resumes the same frame.
- A write to IFG during WAIT does not affect the current gap.
- Clear (CTRL bit1) zeroes FRAME_CNT, len_ovf and too_long. If clear and a tlast accept occur in the same cycle, clear wins for FRAME_CNT (result 0) but LAST_* still update.
- Reset mid-frame discards the frame; the next beat after reset starts a new frame.

Optional Feature:
- Macro: FRAME_RECEPTOR_MAXLEN_EN.
- When defined:
  - CSR 11..12 is MAX_LEN, RW, reset 0; 0 means unlimited.
  - Once len_run would exceed MAX_LEN, the remaining beats of the frame are still accepted (tready unchanged) but excluded from cksum_run and len_run, and too_long is set.
  - At tlast the truncated results latch normally.
- When undefined: addresses 11..12 read 0, too_long is always 0, and there is no length limit.

Test Plan:
- Reset, then read CSR 0..10 -> all read 0x00, and tready=0 until CTRL=0x01 is written.
- DATA_W=16, CTRL=1, IFG=0. Send 3 beats 0x0201, 0x0403, 0x0605 (tlast on beat 3, tkeep=2'b11) -> LAST_CKSUM=0x15, LAST_LEN=6, FRAME_CNT=1, and tready never drops.
- Last beat tkeep=2'b01 with data 0xFF07 -> only 0x07 added, LAST_LEN odd (5 for a 3-beat frame).
- IFG=4 with back-to-back frames and tvalid held high -> tready low exactly 4 cycles after each tlast accept; FRAME_CNT=2 after two frames.
- Write CTRL=0x00 mid-frame for 10 cycles, then CTRL=0x01 -> beats resume and the checksum equals the uninterrupted reference.
- With FRAME_RECEPTOR_MAXLEN_EN and MAX_LEN=4, send a 6-byte frame -> LAST_LEN=4, LAST_CKSUM covers bytes 1..4, STATUS bit2=1; writing CTRL=0x03 clears it.
